friscv_inst_mem_responder: RTL and testbench

- Responder end of the instruction fetch interface. The control unit is the initiator: it drives inst_en and inst_addr, and waits for inst_ready and inst_rdata.
- Word-organised instruction RAM with a configurable read latency and a backdoor load port used by benches and boot loaders.
- Sits between the control unit fetch port and the platform program memory.

---
 rtl/friscv_inst_mem_responder_if.sv | 31 +++
 rtl/friscv_inst_mem_responder.sv | 129 ++++++++++++
 tb/tb_friscv_inst_mem_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/friscv_inst_mem_responder_if.sv
// ============================================================================
// friscv_inst_mem_responder_if : instruction fetch bus plus backdoor load port
// Rev 1.0
// ============================================================================
`default_nettype none

interface friscv_inst_mem_responder_if #(
   parameter int ADDRW = 16,
   parameter int XLEN  = 32
);
   logic             inst_en;
   logic [ADDRW-1:0] inst_addr;
   logic [XLEN-1:0]  inst_rdata;
   logic             inst_ready;
   logic             inst_err;
   logic             load_wr;
   logic [ADDRW-1:0] load_addr;
   logic [XLEN-1:0]  load_data;

   modport master (
      output inst_en, inst_addr, load_wr, load_addr, load_data,
      input  inst_rdata, inst_ready, inst_err
   );

   modport slave (
      input  inst_en, inst_addr, load_wr, load_addr, load_data,
      output inst_rdata, inst_ready, inst_err
   );
endinterface

`default_nettype wire

// File: rtl/friscv_inst_mem_responder.sv
// ============================================================================
// friscv_inst_mem_responder : word RAM answering instruction fetches after
// LATENCY cycles; optional fault checks under FRISCV_IMEM_FAULT_CHECK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module friscv_inst_mem_responder #(
   parameter int ADDRW   = 16,
   parameter int XLEN    = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  wire logic                   aclk,
   input  wire logic                   srst,
   friscv_inst_mem_responder_if.slave  bus
);

   localparam int             IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]     CNT_INIT = 4'(LATENCY - 1);
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [XLEN-1:0] mem [DEPTH];

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [3:0]      cnt;
   logic [XLEN-1:0] data_q;
   logic            accept;
   logic [IDXW-1:0] rd_idx;
   logic [IDXW-1:0] wr_idx;
   logic            wr_ok;
   logic            resp_bad;

   assign accept = (state == S_IDLE) && bus.inst_en;
   assign rd_idx = bus.inst_addr[IDXW+1:2];
   assign wr_idx = bus.load_addr[IDXW+1:2];

   // Byte-offset and above-depth address bits only matter to the fault checks.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.inst_addr, bus.load_addr};

`ifdef FRISCV_IMEM_FAULT_CHECK_EN
   logic req_bad;
   logic bad_q;

   assign req_bad = (bus.inst_addr[1:0] != 2'b00)
                 || (32'(bus.inst_addr[ADDRW-1:2]) >= 32'(DEPTH));
   assign wr_ok   = bus.load_wr && (32'(bus.load_addr[ADDRW-1:2]) < 32'(DEPTH));

   always_ff @(posedge aclk) begin
      if (srst) begin
         bad_q <= 1'b0;
      end else if (accept) begin
         bad_q <= req_bad;
      end
   end

   assign resp_bad = bad_q;
`else
   assign wr_ok    = bus.load_wr;
   assign resp_bad = 1'b0;
`endif

   // Backdoor writes are unaffected by srst; the fetch read below sees old data.
   always_ff @(posedge aclk) begin
      if (wr_ok) begin
         mem[wr_idx] <= bus.load_data;
      end
   end

   always_ff @(posedge aclk) begin
      if (accept) begin
         data_q <= mem[rd_idx];
      end
   end

   // State register
   always_ff @(posedge aclk) begin
      if (srst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= CNT_INIT;
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next-state logic; WAIT ignores inst_en so a flushed request still answers.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.inst_en) begin
               state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd1) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.inst_ready = 1'b0;
      bus.inst_rdata = '0;
      bus.inst_err   = 1'b0;
      if (state == S_RESP) begin
         bus.inst_ready = 1'b1;
         bus.inst_rdata = resp_bad ? NOP_INST : data_q;
         bus.inst_err   = resp_bad;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_friscv_inst_mem_responder.sv
// ============================================================================
// tb_friscv_inst_mem_responder : directed checks on LATENCY 1, 3 and 4 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_friscv_inst_mem_responder;

   localparam int ADDRW = 16;
   localparam int XLEN  = 32;
   localparam int DEPTH = 1024;

   localparam logic [31:0] W_A0  = 32'h0000_0093;
   localparam logic [31:0] W_A1  = 32'h0010_0113;
   localparam logic [31:0] W_LW  = 32'h00C1_2403;
   localparam logic [31:0] W_C2  = 32'h0020_0193;
   localparam logic [31:0] W_D2  = 32'h0030_0193;
   localparam logic [31:0] W_OLD = 32'h0050_0293;
   localparam logic [31:0] W_NEW = 32'h00A0_0293;
   localparam logic [31:0] W_BAD = 32'hDEAD_BEEF;

   logic aclk;
   logic srst;
   logic lw;
   logic [ADDRW-1:0] la;
   logic [XLEN-1:0]  ld;
   logic [2:0] rdy;
   int passed;
   int failed;
   int total;
   int cyc;
   int pulses;

   friscv_inst_mem_responder_if #(.ADDRW(ADDRW), .XLEN(XLEN)) if1 ();
   friscv_inst_mem_responder_if #(.ADDRW(ADDRW), .XLEN(XLEN)) if3 ();
   friscv_inst_mem_responder_if #(.ADDRW(ADDRW), .XLEN(XLEN)) if4 ();

   friscv_inst_mem_responder #(.ADDRW(ADDRW), .XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(1))
      u_l1 (.aclk(aclk), .srst(srst), .bus(if1));
   friscv_inst_mem_responder #(.ADDRW(ADDRW), .XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(3))
      u_l3 (.aclk(aclk), .srst(srst), .bus(if3));
   friscv_inst_mem_responder #(.ADDRW(ADDRW), .XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(4))
      u_l4 (.aclk(aclk), .srst(srst), .bus(if4));

   // One shared load port so every instance holds the same image.
   assign if1.load_wr = lw;  assign if1.load_addr = la;  assign if1.load_data = ld;
   assign if3.load_wr = lw;  assign if3.load_addr = la;  assign if3.load_data = ld;
   assign if4.load_wr = lw;  assign if4.load_addr = la;  assign if4.load_data = ld;
   assign rdy = {if4.inst_ready, if3.inst_ready, if1.inst_ready};

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [ADDRW-1:0] a, input logic [31:0] d);
      lw = 1'b1;
      la = a;
      ld = d;
      tick();
      lw = 1'b0;
   endtask

   // Ticks until the selected instance shows inst_ready; budget+1 on timeout.
   task automatic wait_ready(input int sel, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!rdy[sel] && n <= budget);
   endtask

   // Single fetch on the LATENCY=1 instance.
   task automatic fetch1(input string tag, input logic [ADDRW-1:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
      if1.inst_en   = 1'b1;
      if1.inst_addr = a;
      tick();
      chk({tag, "_ready"}, 32'(if1.inst_ready), 32'd1);
      chk({tag, "_rdata"}, if1.inst_rdata, exp_d);
      chk({tag, "_err"},   32'(if1.inst_err), 32'(exp_e));
      if1.inst_en = 1'b0;
      tick();
      chk({tag, "_pulse"}, 32'(if1.inst_ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      passed = 0; failed = 0; total = 0;
      lw = 1'b0; la = '0; ld = '0;
      if1.inst_en = 1'b0; if1.inst_addr = '0;
      if3.inst_en = 1'b0; if3.inst_addr = '0;
      if4.inst_en = 1'b0; if4.inst_addr = '0;

      // Reset held 3 cycles with requests pending; loads during srst still land.
      srst = 1'b1;
      if1.inst_en = 1'b1; if1.inst_addr = 16'h0010;
      if3.inst_en = 1'b1; if3.inst_addr = 16'h0000;
      lw = 1'b1; la = 16'h0010; ld = W_LW;
      tick();
      chk("rst1_ready1", 32'(if1.inst_ready), 32'd0);
      chk("rst1_rdata1", if1.inst_rdata, 32'd0);
      chk("rst1_err1",   32'(if1.inst_err), 32'd0);
      la = 16'h0000; ld = W_A0;
      tick();
      chk("rst2_ready1", 32'(if1.inst_ready), 32'd0);
      chk("rst2_ready3", 32'(if3.inst_ready), 32'd0);
      la = 16'h0004; ld = W_A1;
      tick();
      chk("rst3_ready1", 32'(if1.inst_ready), 32'd0);
      chk("rst3_rdata3", if3.inst_rdata, 32'd0);
      lw = 1'b0;
      srst = 1'b0;

      // First edge after reset accepts both; LATENCY=1 answers straight away.
      tick();
      chk("l1_ready",  32'(if1.inst_ready), 32'd1);
      chk("l1_rdata",  if1.inst_rdata, W_LW);
      chk("l1_err",    32'(if1.inst_err), 32'd0);
      chk("l3_early",  32'(if3.inst_ready), 32'd0);
      if1.inst_en = 1'b0;
      tick();
      chk("l1_pulse",  32'(if1.inst_ready), 32'd0);
      chk("l1_zero",   if1.inst_rdata, 32'd0);
      chk("l3_early2", 32'(if3.inst_ready), 32'd0);
      tick();
      chk("l3_ready0", 32'(if3.inst_ready), 32'd1);
      chk("l3_rdata0", if3.inst_rdata, W_A0);

      // Back-to-back on LATENCY=3 with inst_en held: pulses 4 cycles apart.
      if3.inst_addr = 16'h0004;
      wait_ready(1, 10, cyc);
      chk("l3_b2b_gap",   32'(cyc), 32'd4);
      chk("l3_rdata1",    if3.inst_rdata, W_A1);
      if3.inst_en = 1'b0;
      tick();
      chk("l3_pulse",     32'(if3.inst_ready), 32'd0);

      // LATENCY=4: flush during WAIT and a load to the captured word.
      load(16'h0008, W_C2);
      if4.inst_en = 1'b1; if4.inst_addr = 16'h0008;
      tick();
      if4.inst_en = 1'b0;
      load(16'h0008, W_D2);
      wait_ready(2, 10, cyc);
      chk("l4_lat",     32'(cyc), 32'd2);
      chk("l4_rdata",   if4.inst_rdata, W_C2);
      tick();
      chk("l4_pulse",   32'(if4.inst_ready), 32'd0);
      if4.inst_en = 1'b1;
      wait_ready(2, 10, cyc);
      chk("l4_lat2",    32'(cyc), 32'd4);
      chk("l4_rdata2",  if4.inst_rdata, W_D2);
      if4.inst_en = 1'b0;
      tick();

      // Write collision: load and fetch of word 5 in the same cycle.
      load(16'h0014, W_OLD);
      if1.inst_en = 1'b1; if1.inst_addr = 16'h0014;
      lw = 1'b1; la = 16'h0014; ld = W_NEW;
      tick();
      lw = 1'b0;
      chk("coll_ready", 32'(if1.inst_ready), 32'd1);
      chk("coll_old",   if1.inst_rdata, W_OLD);
      if1.inst_en = 1'b0;
      tick();
      fetch1("coll_new", 16'h0014, W_NEW, 1'b0);

      // Reset during WAIT drops the pending response.
      if4.inst_en = 1'b1; if4.inst_addr = 16'h0008;
      tick();
      if4.inst_en = 1'b0;
      tick();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      chk("midrst_ready", 32'(if4.inst_ready), 32'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (if4.inst_ready) pulses++;
      end
      chk("midrst_none", 32'(pulses), 32'd0);
      if4.inst_en = 1'b1;
      wait_ready(2, 10, cyc);
      chk("midrst_recover", 32'(cyc), 32'd4);
      chk("midrst_rdata",   if4.inst_rdata, W_D2);
      if4.inst_en = 1'b0;
      tick();

`ifdef FRISCV_IMEM_FAULT_CHECK_EN
      fetch1("flt_misal", 16'h0002, 32'h0000_0013, 1'b1);
      fetch1("flt_range", 16'(DEPTH * 4), 32'h0000_0013, 1'b1);
      fetch1("flt_ok",    16'h0008, W_D2, 1'b0);
      load(16'(DEPTH * 4), W_BAD);
      fetch1("flt_wrdrop", 16'h0000, W_A0, 1'b0);
`else
      fetch1("wrap_misal", 16'h0002, W_A0, 1'b0);
      fetch1("wrap_range", 16'(DEPTH * 4), W_A0, 1'b0);
      fetch1("wrap_ok",    16'h0008, W_D2, 1'b0);
      load(16'(DEPTH * 4), W_BAD);
      fetch1("wrap_wr",    16'h0000, W_BAD, 1'b0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
